pll_reset_sequencer: RTL
========================

# pll_reset_sequencer

Controls the board PLL and sequences system reset from its lock status. Runs on the free-running 25 MHz board clock that feeds the PLL. The block pulses the PLL reset, waits for a stable lock, and holds the core in reset until the PLL output is trustworthy. On loss of lock or lock timeout it restarts the PLL, and it exposes status and event counters for the CSR/debug path.

## Interface
- `PLL_RST_CYCLES`, default 8: cycles `pll_rst` is held high per PLL restart (≥1).
- `LOCK_STABLE_CYCLES`, default 1024: consecutive synchronized-lock-high cycles required before leaving WAIT_LOCK (≥1).
- `LOCK_TIMEOUT`, default 65536: maximum cycles in WAIT_LOCK before the PLL is restarted. Must be greater than `LOCK_STABLE_CYCLES`.
- `RESET_HOLD_CYCLES`, default 16: extra cycles `sys_reset` stays high after stable lock (≥1).
- `clock` in 1: 25 MHz board clock, the PLL reference; the block's only clock.
- `reset` in 1: asynchronous, active-high; returns the block to PLL_RESET.
- `pll_lock` in 1: PLL LOCK output, asynchronous to `clock`.
- `pll_rst` out 1: PLL reset request, active-high.
- `sys_reset` out 1: active-high core reset. Consumers in the PLL output domain resynchronize its deassertion.
- `locked` out 1: high only in RUN.
- `loss_count` out 8: lock losses seen in HOLD or RUN; saturating.
- `timeout_count` out 8: WAIT_LOCK timeouts; saturating.

## Operation
- **Synchronizer:** `pll_lock` passes through a 2-flop synchronizer, both flops reset to 0, to produce `lock_s`. No other logic samples `pll_lock` directly.
- **State machine (registered):** PLL_RESET → WAIT_LOCK → HOLD → RUN. One shared cycle counter `cnt` and a separate timeout counter `tcnt`. Each counter is sized to `ceil(log2)` of its largest parameter.
- **PLL_RESET:** increment `cnt` each cycle. When `cnt == PLL_RST_CYCLES-1`, go to WAIT_LOCK and clear `cnt` and `tcnt`.
- **WAIT_LOCK:** `tcnt` increments every cycle. Evaluate these in priority order:
  1. If `lock_s=1` and `cnt == LOCK_STABLE_CYCLES-1`, go to HOLD and clear `cnt`.
  2. Else if `tcnt == LOCK_TIMEOUT-1`, go to PLL_RESET, clear `cnt`, and increment `timeout_count`.
  3. Else if `lock_s=1`, increment `cnt`.
  4. Else clear `cnt`. A lock glitch restarts the stability window.
- **Simultaneous stable-reached and timeout:** HOLD wins; no timeout is counted.
- **HOLD:** if `lock_s=0`, go to PLL_RESET, clear `cnt`, and increment `loss_count`. Else if `cnt == RESET_HOLD_CYCLES-1`, go to RUN. Else increment `cnt`.
- **RUN:** if `lock_s=0`, go to PLL_RESET, clear `cnt`, and increment `loss_count`. Otherwise stay in RUN.
- **Output decode:** outputs are Moore decodes of the state register and change on the same edge as the state.
  - `pll_rst = (PLL_RESET)`
  - `sys_reset = !(RUN)`
  - `locked = (RUN)`
- **Counter saturation:** both event counters stop at 255 and never wrap.
- **Reset (including mid-operation):** asynchronously forces the following regardless of prior state:
  - state = PLL_RESET, with `cnt`, `tcnt` and synchronizer flops at 0
  - `pll_rst=1`, `sys_reset=1`, `locked=0`
  - `loss_count=0`, `timeout_count=0`

## Timing
- Edge 0 is the first rising `clock` edge after `reset` deasserts.
- `pll_rst` is high throughout reset and through edges 0..`PLL_RST_CYCLES-1`. It falls after edge `PLL_RST_CYCLES-1`.
- **Lock-input latency:** `lock_s` lags `pll_lock` by 2 edges.
- **Minimum time to RUN** with `pll_lock` held high from reset: `PLL_RST_CYCLES + LOCK_STABLE_CYCLES + RESET_HOLD_CYCLES` edges.
- **Loss-of-lock response:** `pll_lock` falling is seen by `lock_s` 2 edges later. `sys_reset` and `pll_rst` rise, and `locked` falls, on the next edge, 3 edges after the fall.
- **Restart timing:** a timeout asserts `pll_rst` on the edge after the `LOCK_TIMEOUT`-th WAIT_LOCK cycle.
- **Glitch filtering:** a lock glitch of any width ≥1 cycle at `lock_s` resets the stability count.

## Test plan
- **Clean lock.** Parameters 8/16/1000/4; `pll_lock=1` from reset. Required:
  - `pll_rst` falls after edge 7.
  - `sys_reset` falls and `locked` rises after edge 27.
  - Both counts remain 0.
- **Glitch in WAIT_LOCK.** Same parameters; drop `pll_lock` for 1 cycle mid-window. Required:
  - RUN entry is delayed by exactly (glitch position + 1) stability cycles.
  - `loss_count=0`.
- **Timeout.** `LOCK_TIMEOUT=100`; `pll_lock=0`. Required:
  - `pll_rst` re-asserts 100 cycles after entering WAIT_LOCK.
  - `timeout_count` increments once per restart.
  - After 300 restarts, `timeout_count` is saturated at 255.
- **Loss in RUN.** After reaching RUN, drop `pll_lock`. Required:
  - `locked` falls and `sys_reset`/`pll_rst` rise exactly 3 edges later.
  - `loss_count=1`.
  - Full resequence to RUN after re-lock.
- **Loss in HOLD.** Drop `pll_lock` during HOLD. Required:
  - Return to PLL_RESET.
  - `loss_count` increments.
  - `sys_reset` never deasserts.
- **Reset mid-operation.** Assert `reset` asynchronously while in RUN and mid-WAIT_LOCK. Required:
  - Outputs reach reset values immediately, without waiting for a clock edge.
  - Counters clear.
  - The sequence restarts from edge 0.

Source files
------------

// File: rtl/pll_reset_sequencer_if.sv
// Lock/status bundle between the PLL reset sequencer and its surroundings.
// The master side is the sequencer; the slave side is the PLL/CSR environment.
interface pll_reset_sequencer_if;
   logic       pll_lock;
   logic       pll_rst;
   logic       sys_reset;
   logic       locked;
   logic [7:0] loss_count;
   logic [7:0] timeout_count;

   modport master (
      input  pll_lock,
      output pll_rst, sys_reset, locked, loss_count, timeout_count
   );

   modport slave (
      output pll_lock,
      input  pll_rst, sys_reset, locked, loss_count, timeout_count
   );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Pulses the PLL reset, waits for a stable synchronized lock, then releases the
// core reset; restarts the PLL on lock loss or lock timeout and counts both events.
module pll_reset_sequencer #(
   parameter int unsigned PLL_RST_CYCLES     = 8,
   parameter int unsigned LOCK_STABLE_CYCLES = 1024,
   parameter int unsigned LOCK_TIMEOUT       = 65536,
   parameter int unsigned RESET_HOLD_CYCLES  = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   pll_reset_sequencer_if.master bus
);

   localparam int unsigned MAX_A   = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
   localparam int unsigned CNT_MAX = (MAX_A > RESET_HOLD_CYCLES) ? MAX_A : RESET_HOLD_CYCLES;
   localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int unsigned TW      = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

   localparam logic [CW-1:0] RST_LAST    = CW'(PLL_RST_CYCLES - 1);
   localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LAST   = CW'(RESET_HOLD_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LAST    = TW'(LOCK_TIMEOUT - 1);

   typedef enum logic [1:0] {
      PLL_RESET = 2'd0,
      WAIT_LOCK = 2'd1,
      HOLD      = 2'd2,
      RUN       = 2'd3
   } state_t;

   state_t        state_r;
   logic [CW-1:0] cnt;
   logic [TW-1:0] tcnt;
   logic          lock_meta_r;
   logic          lock_s;
   logic          pll_rst_r;
   logic          sys_reset_r;
   logic          locked_r;
   logic [7:0]    loss_count_r;
   logic [7:0]    timeout_count_r;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      sat_inc = (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Two-flop synchronizer for the asynchronous PLL lock.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lock_meta_r <= 1'b0;
         lock_s      <= 1'b0;
      end else begin
         lock_meta_r <= bus.pll_lock;
         lock_s      <= lock_meta_r;
      end
   end

   // Sequencer FSM; outputs are registered alongside the state so they move on the same edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r         <= PLL_RESET;
         cnt             <= '0;
         tcnt            <= '0;
         pll_rst_r       <= 1'b1;
         sys_reset_r     <= 1'b1;
         locked_r        <= 1'b0;
         loss_count_r    <= 8'd0;
         timeout_count_r <= 8'd0;
      end else begin
         case (state_r)
            PLL_RESET: begin
               if (cnt == RST_LAST) begin
                  state_r   <= WAIT_LOCK;
                  cnt       <= '0;
                  tcnt      <= '0;
                  pll_rst_r <= 1'b0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            WAIT_LOCK: begin
               tcnt <= tcnt + TW'(1);
               // Stable lock beats a coincident timeout.
               if (lock_s && (cnt == STABLE_LAST)) begin
                  state_r <= HOLD;
                  cnt     <= '0;
               end else if (tcnt == TMO_LAST) begin
                  state_r         <= PLL_RESET;
                  cnt             <= '0;
                  pll_rst_r       <= 1'b1;
                  timeout_count_r <= sat_inc(timeout_count_r);
               end else if (lock_s) begin
                  cnt <= cnt + CW'(1);
               end else begin
                  cnt <= '0;
               end
            end
            HOLD: begin
               if (!lock_s) begin
                  state_r      <= PLL_RESET;
                  cnt          <= '0;
                  pll_rst_r    <= 1'b1;
                  loss_count_r <= sat_inc(loss_count_r);
               end else if (cnt == HOLD_LAST) begin
                  state_r     <= RUN;
                  cnt         <= '0;
                  sys_reset_r <= 1'b0;
                  locked_r    <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            RUN: begin
               if (!lock_s) begin
                  state_r      <= PLL_RESET;
                  cnt          <= '0;
                  pll_rst_r    <= 1'b1;
                  sys_reset_r  <= 1'b1;
                  locked_r     <= 1'b0;
                  loss_count_r <= sat_inc(loss_count_r);
               end else begin
                  state_r <= RUN;
               end
            end
            default: begin
               state_r     <= PLL_RESET;
               cnt         <= '0;
               tcnt        <= '0;
               pll_rst_r   <= 1'b1;
               sys_reset_r <= 1'b1;
               locked_r    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pll_rst       = pll_rst_r;
   assign bus.sys_reset     = sys_reset_r;
   assign bus.locked        = locked_r;
   assign bus.loss_count    = loss_count_r;
   assign bus.timeout_count = timeout_count_r;

endmodule
